// File: rtl/sfifo_flags_if.sv
// Handshake bundle for the single-clock FIFO: producer/consumer requests in,
// data and status flags out. The FIFO takes the slave side.
`timescale 1ns/1ps
interface sfifo_flags_if #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 8
);
    logic             i_flush;
    logic             i_wr;
    logic [DSIZE-1:0] i_wdata;
    logic             o_wfull;
    logic             o_afull;
    logic             i_rd;
    logic [DSIZE-1:0] o_rdata;
    logic             o_rempty;
    logic             o_aempty;
    logic [ASIZE:0]   o_count;
    logic             o_ovf;
    logic             o_udf;

    modport master (
        output i_flush, i_wr, i_wdata, i_rd,
        input  o_wfull, o_afull, o_rdata, o_rempty, o_aempty, o_count, o_ovf, o_udf
    );

    modport slave (
        input  i_flush, i_wr, i_wdata, i_rd,
        output o_wfull, o_afull, o_rdata, o_rempty, o_aempty, o_count, o_ovf, o_udf
    );
endinterface

// File: rtl/sfifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds, sticky
// overflow/underflow, synchronous flush and standard or fall-through read.
`timescale 1ns/1ps
module sfifo_flags #(
    parameter int DSIZE     = 16,
    parameter int ASIZE     = 8,
    parameter int AFULL_TH  = (1 << ASIZE) - 4,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    sfifo_flags_if.slave  bus
);
    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             full, empty, wa, ra;

    // Accept decisions use the pre-edge flags, so a simultaneous read never
    // rescues a write at full and a simultaneous write never rescues a read at empty.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign wa    = bus.i_wr & ~full  & ~bus.i_flush;
    assign ra    = bus.i_rd & ~empty & ~bus.i_flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (bus.i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wa) wptr_d = wptr_q + ASIZE'(1);
            if (ra) rptr_d = rptr_q + ASIZE'(1);
            case ({wa, ra})
                2'b10:   count_d = count_q + (ASIZE+1)'(1);
                2'b01:   count_d = count_q - (ASIZE+1)'(1);
                default: count_d = count_q;
            endcase
            if (bus.i_wr & full)  ovf_d = 1'b1;
            if (bus.i_rd & empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (wa) mem_q[wptr_q] <= bus.i_wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.o_rdata = mem_q[rptr_q];
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)  rdata_q <= '0;
                else if (ra)   rdata_q <= mem_q[rptr_q];
            end
            assign bus.o_rdata = rdata_q;
        end
    endgenerate

    assign bus.o_wfull  = full;
    assign bus.o_rempty = empty;
    assign bus.o_afull  = (count_q >= AFULL_C);
    assign bus.o_aempty = (count_q <= AEMPTY_C);
    assign bus.o_count  = count_q;
    assign bus.o_ovf    = ovf_q;
    assign bus.o_udf    = udf_q;
endmodule

// File: doc/sfifo_flags.md
# sfifo_flags

Single-clock, parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds, fill-level output, selectable standard or first-word-fall-through (FWFT) read mode, sticky overflow/underflow flags and synchronous flush. It is the same-clock companion to the dual-clock FIFO. It buffers data words between a producer and a consumer in one clock domain, such as a DMD data path stage or a command queue.

## Interface
- DSIZE, 16, data word width in bits (1..64)
- ASIZE, 8, address width; DEPTH = 2^ASIZE words (2..12)
- AFULL_TH, 2^ASIZE-4, o_afull asserts when count >= AFULL_TH; must satisfy AEMPTY_TH < AFULL_TH <= DEPTH
- AEMPTY_TH, 4, o_aempty asserts when count <= AEMPTY_TH; must be >= 0
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
- i_clk  in  1  single clock; all logic on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_flush  in  1  synchronous flush: empties FIFO and clears sticky flags
- i_wr  in  1  write request
- i_wdata  in  DSIZE  write data
- o_wfull  out  1  count == DEPTH
- o_afull  out  1  count >= AFULL_TH
- i_rd  in  1  read request (FWFT=1: pop head word)
- o_rdata  out  DSIZE  read data
- o_rempty  out  1  count == 0
- o_aempty  out  1  count <= AEMPTY_TH
- o_count  out  ASIZE+1  words currently stored, 0..DEPTH
- o_ovf  out  1  sticky: write attempted while full
- o_udf  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DSIZE register array. Write and read pointers are ASIZE bits wide and wrap modulo DEPTH. The array is not reset.
- Write accept: wa = i_wr & ~o_wfull. The write is judged on the pre-edge full flag, so a write while full is dropped even when a read in the same cycle frees a slot.
- Read accept: ra = i_rd & ~o_rempty. The read is judged on the pre-edge empty flag, so a read while empty is rejected even when a write occurs in the same cycle.
- Count update: count_next = count + wa - ra. When wa and ra are both set, the count is unchanged and both pointers advance.
- Flags: o_wfull, o_afull, o_rempty and o_aempty are decoded from the registered count, so they change only on clock edges.
- Overflow: i_wr & o_wfull sets o_ovf. Memory, pointers and count are unchanged.
- Underflow: i_rd & o_rempty sets o_udf. o_rdata holds its previous value in FWFT=0.
- Sticky flags stay set until i_flush or reset.
- Flush: i_flush has priority over i_wr and i_rd in the same cycle. It zeroes both pointers, the count, o_ovf and o_udf. It does not set o_ovf or o_udf.
- FWFT=0 read data: o_rdata is a register loaded with mem[rptr] on an accepted read and holds otherwise.
- FWFT=1 read data: o_rdata = mem[rptr] combinationally. It is valid whenever o_rempty=0 and undefined (don't-care) when empty.
- Reset values: pointers 0, o_count 0, o_rempty 1, o_aempty 1, o_wfull 0, o_afull 0 (0 also when AFULL_TH > 0), o_ovf 0, o_udf 0, o_rdata 0 (FWFT=0).

## Timing
- Write to visible: a write accepted at edge N gives o_count+1 and updates flags after edge N. In FWFT=1, o_rdata shows that word after edge N if the FIFO was empty.
- FWFT=0 read latency: 1 cycle. A read accepted at edge N presents its data on o_rdata after edge N, held until the next accepted read.
- FWFT=1 read latency: 0 cycles. The head word is present before i_rd; after a pop at edge N, the next word appears after edge N.
- Full/empty reaction: 1 cycle, registered. Back-to-back writes every cycle reach o_wfull after exactly DEPTH accepted writes.
- Pointer wrap: rptr and wptr roll from DEPTH-1 to 0 with no gap in data order.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). Operation resumes on the first edge after i_rst_n rises.
- Throughput: 1 write and 1 read per cycle sustained.

## Test plan
- Single word (FWFT=0, DSIZE=16, ASIZE=8): reset for 100 ns, write 16'h1234 once, then pulse i_rd on the cycle after o_rempty falls. Required: o_count 0->1->0, o_rdata=16'h1234 one cycle after the read, no o_udf.
- Fill/overflow: write 16'h1235.. for 257 consecutive cycles with no reads. Required: o_afull at count 252, o_wfull at count 256, o_ovf=1 after the 257th write, then reading all 256 words returns 16'h1235..16'h1334 in order.
- Simultaneous at boundaries:
  - At count=256 assert i_wr and i_rd together: required count 255, o_ovf=1, and the written word is not stored.
  - At count=0 assert both: required count 1, o_udf=1.
  - At count=10 assert both for 300 cycles: required count stays 10 and pointers wrap with data in order.
- FWFT=1: write 16'hA5A5 then 16'h5A5A. Required: o_rdata=16'hA5A5 the cycle after the first write, before any i_rd; one pop then shows 16'h5A5A.
- Flush: at count=100 with o_ovf=1, assert i_flush, i_wr and i_rd together. Required: next cycle count=0, o_rempty=1, o_aempty=1, o_ovf=0, o_udf=0.
- Reset mid-burst: drop i_rst_n during a 100-word write burst. Required: all outputs at their reset values while reset is low, and after release the first write/read pair returns the first word written after reset.
